fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the core. Owns the fetch PC and drives the instruction-memory
//  request/address, and drives inst_sel into inst_mgmt: pass rdata, insert NOP, or hold the last word.
//  Handles memory wait states, pipeline stalls and branch redirects with a programmable flush bubble.
// PARAMETERS
//  RESET_PC      32'h0000_0000  fetch address loaded on reset
//  FLUSH_CYCLES  1              NOP bubbles after a redirect (0..15; 0 = no FLUSH state)
// PORTS
//  clk            in   1   core clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  mem_ready      in   1   rdata for addr is valid this cycle
//  stall          in   1   downstream stall; hold current instruction
//  branch_taken   in   1   redirect request, one-cycle pulse
//  branch_target  in   32  redirect address
//  req            out  1   instruction-memory read request
//  addr           out  32  instruction-memory address
//  pc             out  32  address of the instruction selected into inst_mgmt
//  inst_sel       out  2   to inst_mgmt: 2'b00 pass rdata, 2'b01 NOP, 2'b10 hold, 2'b11 unused
//  inst_valid     out  1   inst_mgmt output is a real instruction this cycle
//  misalign       out  1   sticky misaligned-target flag (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs are registered. Inputs are sampled at the rising edge of clk, and outputs update at that edge.
//  - Reset (async, any time, including mid-flush): state=IDLE, addr=pc=RESET_PC, req=0,
//    inst_sel=2'b01, inst_valid=0, misalign=0, flush_cnt=0.
//  - States: IDLE, RUN, FLUSH, HALT (HALT exists only with the macro).
//  - IDLE: on the first edge after rst deasserts -> RUN with req=1. Inputs are ignored in IDLE.
//  - RUN: req=1. Priority is branch_taken > stall > mem_ready.
//    * branch_taken:
//        addr<=target, inst_sel<=01, inst_valid<=0, flush_cnt<=FLUSH_CYCLES.
//        Next state is FLUSH if FLUSH_CYCLES>0, else RUN. Any in-flight rdata is discarded.
//    * stall (no branch): addr and pc held, inst_sel<=10, inst_valid<=0.
//        If mem_ready is also 1, that word is discarded and refetched from the same addr after the stall.
//    * mem_ready: pc<=addr, addr<=addr+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), inst_sel<=00, inst_valid<=1.
//    * none of the above (memory wait): addr held, inst_sel<=01, inst_valid<=0.
//  - FLUSH: req=0, inst_sel=01, inst_valid=0.
//    * flush_cnt decrements each edge; when it reaches 1, the next state is RUN.
//    * branch_taken in FLUSH: reload addr and flush_cnt, stay in FLUSH.
//    * stall is ignored in FLUSH.
//  - Fetch latency: the first mem_ready in RUN gives inst_sel=00 and inst_valid=1 on that same edge.
//    Redirect to first valid instruction takes FLUSH_CYCLES+1 edges plus memory wait.
//  - pc changes only on edges where inst_valid is set to 1.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    * In RUN or FLUSH, branch_taken with branch_target[1:0]!=0 sets misalign<=1 (sticky until rst).
//    * Next state is HALT, with req=0, inst_sel=01, inst_valid=0; addr and pc are frozen.
//    * HALT is left only by rst.
//  MISALIGN_TRAP_EN undefined:
//    * target[1:0] is forced to 2'b00 before loading addr.
//    * misalign is tied to 0 and HALT is never entered.
// TESTING
//  1. rst 1->0, mem_ready=1, stall=0 -> IDLE 1 edge, then addr 0,4,8,...; inst_sel=00; inst_valid=1; pc lags addr by 1 fetch.
//  2. mem_ready=0 for 3 edges at addr=8 -> inst_sel=01 and inst_valid=0 for 3 edges, addr stays 8; resumes with pc=8.
//  3. stall=1 for 2 edges with mem_ready=1 at addr=0xC -> inst_sel=10 for 2 edges, addr stays 0xC; then pc=0xC, addr=0x10.
//  4. FLUSH_CYCLES=2, branch_taken+stall together, target=0xFFFF_FFFC -> 2 edges req=0 and inst_sel=01;
//     then pc=0xFFFF_FFFC; then addr wraps to 0x0.
//  5. target=0x102: with MISALIGN_TRAP_EN -> misalign=1, HALT, req=0 until rst;
//     without the macro -> addr=0x100, misalign=0.
//  6. Assert rst during FLUSH, 5 ns after a clk edge -> outputs at reset values immediately,
//     without waiting for a clock edge; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: instruction-fetch handshake between fetch_ctrl, instruction memory and inst_mgmt
interface fetch_if;
    logic        mem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [1:0]  inst_sel;
    logic        inst_valid;
    logic        misalign;
    modport master (
        input  mem_ready, stall, branch_taken, branch_target,
        output req, addr, pc, inst_sel, inst_valid, misalign
    );
    modport slave (
        output mem_ready, stall, branch_taken, branch_target,
        input  req, addr, pc, inst_sel, inst_valid, misalign
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer with wait/stall/redirect handling; MISALIGN_TRAP_EN enables misaligned-branch HALT
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input logic   clk,
    input logic   rst,
    fetch_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;
    localparam logic [1:0] SEL_PASS = 2'b00;
    localparam logic [1:0] SEL_NOP  = 2'b01;
    localparam logic [1:0] SEL_HOLD = 2'b10;
    localparam logic [3:0] FLUSH_N  = 4'(FLUSH_CYCLES);
    logic [1:0]  state;
    logic [3:0]  flush_cnt;
    logic [31:0] target;
    logic        bad;
    // redirect address and misalignment detection for the configured build
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        target = bus.branch_target;
        bad    = |bus.branch_target[1:0];
`else
        target = {bus.branch_target[31:2], 2'b00};
        bad    = 1'b0;
`endif
    end
    // fetch state machine; every output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            bus.req        <= 1'b0;
            bus.addr       <= RESET_PC;
            bus.pc         <= RESET_PC;
            bus.inst_sel   <= SEL_NOP;
            bus.inst_valid <= 1'b0;
            bus.misalign   <= 1'b0;
        end else if (state == IDLE) begin
            state   <= RUN;
            bus.req <= 1'b1;
        end else if (state == RUN || state == FLUSH) begin
            if (bus.branch_taken && bad) begin
                state          <= HALT;
                bus.misalign   <= 1'b1;
                bus.req        <= 1'b0;
                bus.inst_sel   <= SEL_NOP;
                bus.inst_valid <= 1'b0;
            end else if (bus.branch_taken) begin
                state          <= (FLUSH_N != 4'd0) ? FLUSH : RUN;
                flush_cnt      <= FLUSH_N;
                bus.req        <= (FLUSH_N == 4'd0);
                bus.addr       <= target;
                bus.inst_sel   <= SEL_NOP;
                bus.inst_valid <= 1'b0;
            end else if (state == FLUSH) begin
                state          <= (flush_cnt <= 4'd1) ? RUN : FLUSH;
                flush_cnt      <= (flush_cnt <= 4'd1) ? 4'd0 : flush_cnt - 4'd1;
                bus.req        <= (flush_cnt <= 4'd1);
                bus.inst_sel   <= SEL_NOP;
                bus.inst_valid <= 1'b0;
            end else if (bus.stall) begin
                bus.inst_sel   <= SEL_HOLD;
                bus.inst_valid <= 1'b0;
            end else if (bus.mem_ready) begin
                bus.pc         <= bus.addr;
                bus.addr       <= bus.addr + 32'd4;
                bus.inst_sel   <= SEL_PASS;
                bus.inst_valid <= 1'b1;
            end else begin
                bus.inst_sel   <= SEL_NOP;
                bus.inst_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl (FLUSH_CYCLES=2)
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    fetch_if bus ();
    fetch_ctrl #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_out(input string tag, input logic req, input logic [1:0] sel,
                              input logic valid, input logic [31:0] addr, input logic [31:0] pc);
        chk({tag, ".req"}, 32'(bus.req), 32'(req));
        chk({tag, ".sel"}, 32'(bus.inst_sel), 32'(sel));
        chk({tag, ".valid"}, 32'(bus.inst_valid), 32'(valid));
        chk({tag, ".addr"}, bus.addr, addr);
        chk({tag, ".pc"}, bus.pc, pc);
    endtask
    initial begin
        bus.mem_ready     = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        tick();
        expect_out("reset", 1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        chk("reset.misalign", 32'(bus.misalign), 32'h0);
        rst = 1'b0;
        tick();
        expect_out("idle", 1'b1, 2'b01, 1'b0, 32'h0, 32'h0);
        tick();
        expect_out("run0", 1'b1, 2'b00, 1'b1, 32'h4, 32'h0);
        tick();
        expect_out("run1", 1'b1, 2'b00, 1'b1, 32'h8, 32'h4);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("wait%0d", i), 1'b1, 2'b01, 1'b0, 32'h8, 32'h4);
        end
        bus.mem_ready = 1'b1;
        tick();
        expect_out("resume", 1'b1, 2'b00, 1'b1, 32'hC, 32'h8);
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out($sformatf("stall%0d", i), 1'b1, 2'b10, 1'b0, 32'hC, 32'h8);
        end
        bus.stall = 1'b0;
        tick();
        expect_out("unstall", 1'b1, 2'b00, 1'b1, 32'h10, 32'hC);
        bus.branch_taken  = 1'b1;
        bus.stall         = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        tick();
        expect_out("br_edge", 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'hC);
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b0;
        tick();
        expect_out("flush1", 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'hC);
        tick();
        expect_out("flush_exit", 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'hC);
        tick();
        expect_out("br_first", 1'b1, 2'b00, 1'b1, 32'h0, 32'hFFFF_FFFC);
        tick();
        expect_out("wrap", 1'b1, 2'b00, 1'b1, 32'h4, 32'h0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0102;
        tick();
`ifdef MISALIGN_TRAP_EN
        expect_out("halt", 1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
        chk("halt.misalign", 32'(bus.misalign), 32'h1);
        bus.branch_target = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("halt_hold%0d", i), 1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
            chk($sformatf("halt_hold%0d.misalign", i), 32'(bus.misalign), 32'h1);
        end
        bus.branch_taken = 1'b0;
`else
        expect_out("align", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
        chk("align.misalign", 32'(bus.misalign), 32'h0);
        bus.branch_taken = 1'b0;
        tick();
        expect_out("fl_a", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0200;
        tick();
        expect_out("fl_reload", 1'b0, 2'b01, 1'b0, 32'h200, 32'h0);
        bus.branch_taken = 1'b0;
        tick();
        expect_out("fl_b", 1'b0, 2'b01, 1'b0, 32'h200, 32'h0);
        tick();
        expect_out("fl_exit", 1'b1, 2'b01, 1'b0, 32'h200, 32'h0);
        tick();
        expect_out("fl_first", 1'b1, 2'b00, 1'b1, 32'h204, 32'h200);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        expect_out("re_idle", 1'b1, 2'b01, 1'b0, 32'h0, 32'h0);
        chk("re_idle.misalign", 32'(bus.misalign), 32'h0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0040;
        tick();
        expect_out("br40", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0);
        bus.branch_taken = 1'b0;
        bus.mem_ready    = 1'b1;
        tick();
        bus.stall = 1'b0;
        expect_out("pre_cnt", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0);
        tick();
        tick();
        expect_out("run40", 1'b1, 2'b00, 1'b1, 32'h44, 32'h40);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0080;
        tick();
        bus.branch_taken = 1'b0;
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        expect_out("async_rst", 1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        chk("async_rst.misalign", 32'(bus.misalign), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        expect_out("restart_idle", 1'b1, 2'b01, 1'b0, 32'h0, 32'h0);
        tick();
        expect_out("restart_run", 1'b1, 2'b00, 1'b1, 32'h4, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
